// File: rtl/inst_fetch.sv
// Read-side sequencer for a dual-port instruction RAM: streams an inclusive address
// range through the fixed-latency read port into a credit-checked output FIFO.
module inst_fetch #(
  parameter int DW         = 32,
  parameter int AW         = 9,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst_data,
  output logic          inst_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc, remaining;
  logic [RD_LAT:0] vld_p, lst_p;
  logic [DW:0]     fifo_mem [FIFO_DEPTH];
  logic [DW:0]     head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     fifo_count;
  logic [CW-1:0]   inflight, credit_used, credit_cap;
  logic            push, pop, issue, last_issue, accept_start;

  // Stage 0 of vld_p/lst_p lines up with rd_addr; stage RD_LAT lines up with rd_data.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) inflight = inflight + CW'(vld_p[i]);
  end

  // A pop this cycle frees a slot, so it counts toward the credit to keep 1/clk.
  assign pop          = inst_valid & inst_ready;
  assign push         = vld_p[RD_LAT];
  assign credit_used  = CW'(fifo_count) + inflight;
  assign credit_cap   = CW'(FIFO_DEPTH) + CW'(pop);
  assign issue        = (state_q == FETCH) && !flush && (credit_used < credit_cap);
  assign last_issue   = issue && (remaining == '0);
  assign accept_start = (state_q == IDLE) && start && !flush;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (last_issue) state_d = DRAIN;
      DRAIN:   if (pop && inst_last) begin
                 state_d = IDLE;
                 done    = 1'b1;
               end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc        <= '0;
      remaining <= '0;
      rd_addr   <= '0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        pc        <= start_addr;
        remaining <= end_addr - start_addr;
      end else if (issue) begin
        pc      <= pc + 1'b1;
        rd_addr <= pc;
        if (remaining != '0) remaining <= remaining - 1'b1;
      end
    end
  end

  // ---- in-flight read tracking: p0 (address reg) .. p[RD_LAT] (data out) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
      lst_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
      lst_p <= '0;
    end else begin
      vld_p <= {vld_p[RD_LAT-1:0], issue};
      lst_p <= {lst_p[RD_LAT-1:0], last_issue};
    end
  end

  // ---- output FIFO ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) fifo_mem[wr_ptr] <= {lst_p[RD_LAT], rd_data};
  end

  assign head       = fifo_mem[rd_ptr];
  assign inst_valid = (fifo_count != '0);
  assign inst_data  = inst_valid ? head[DW-1:0] : '0;
  assign inst_last  = inst_valid & head[DW];
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: RAM model with 2-clock read latency, table of programs plus
// random programs scored against an address-range model, and flush/reset sequences.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  start_addr, end_addr;
  logic        flush;
  logic        busy, done;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data;
  logic        inst_last;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.DW(32), .AW(9), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .flush(flush), .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_last(inst_last)
  );

  always #5 clk = ~clk;

  // RAM read port: address register then output register.
  logic [31:0] ram [512];
  logic [8:0]  addr_q;
  always @(posedge clk) begin
    addr_q  <= rd_addr;
    rd_data <= ram[addr_q];
  end

  function automatic logic [31:0] word_at(input logic [8:0] a);
    return 32'(a) * 32'd3;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [8:0]  sa, ea;
    int          len;
    logic [31:0] first, last;
    int          rmode;
    bit          poke;
  } vec_t;

  task automatic run_program(input logic [8:0] sa, input logic [8:0] ea, input int exp_len,
                             input logic [31:0] exp_first, input logic [31:0] exp_last,
                             input int rmode, input bit poke, input string name);
    logic [31:0] q [$];
    logic        lq [$];
    logic [31:0] first_d, last_d, held_d, ed;
    logic        held_l, el, stalled_prev, finished, done_ok, fire;
    int len, k, got, first_k, sb_err, stab_err, occ_err, done_cnt, idle_err, budget;
    len = int'(9'(ea - sa)) + 1;
    for (int i = 0; i < len; i++) begin
      q.push_back(word_at(9'(sa + 9'(i))));
      lq.push_back(i == len - 1);
    end
    first_d = '0; last_d = '0; held_d = '0; held_l = 0; stalled_prev = 0;
    finished = 0; done_ok = 0; got = 0; first_k = -1; sb_err = 0; stab_err = 0;
    occ_err = 0; done_cnt = 0; idle_err = 0; budget = exp_len * 4 + 60;

    @(negedge clk);
    start_addr = sa; end_addr = ea; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!finished && k < budget) begin
      inst_ready = (rmode == 0) ? 1'b1 : 1'($urandom % 2);
      #1;
      if (inst_valid && first_k < 0) first_k = k;
      if (stalled_prev && (!inst_valid || inst_data !== held_d || inst_last !== held_l))
        stab_err++;
      stalled_prev = inst_valid && !inst_ready;
      held_d = inst_data; held_l = inst_last;
      if ($countones(dut.vld_p) + int'(dut.fifo_count) > 4) occ_err++;
      if (done) done_cnt++;
      fire = inst_valid && inst_ready;
      if (fire) begin
        got++;
        if (q.size() == 0) sb_err++;
        else begin
          ed = q.pop_front(); el = lq.pop_front();
          if (inst_data !== ed || inst_last !== el) sb_err++;
        end
        if (got == 1) first_d = inst_data;
        last_d = inst_data;
        if (inst_last) begin
          finished = 1;
          done_ok = done;
          if (poke) begin start = 1'b1; start_addr = 9'd300; end_addr = 9'd305; end
        end
      end
      if (poke && k == 6) begin start = 1'b1; start_addr = 9'd200; end_addr = 9'd220; end
      else if (poke && k == 7) start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    #1;
    if (busy || done || inst_valid) idle_err++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (busy || done || inst_valid) idle_err++;
    end
    check({name, "_finished"}, 32'(finished), 32'd1);
    check({name, "_latency"}, 32'(first_k), 32'd4);
    check({name, "_count"}, 32'(got), 32'(exp_len));
    check({name, "_first"}, first_d, exp_first);
    check({name, "_lastdata"}, last_d, exp_last);
    check({name, "_order"}, 32'(sb_err), 32'd0);
    check({name, "_done_once"}, 32'(done_cnt), 32'd1);
    check({name, "_done_align"}, 32'(done_ok), 32'd1);
    check({name, "_stable"}, 32'(stab_err), 32'd0);
    check({name, "_occupancy"}, 32'(occ_err), 32'd0);
    check({name, "_idle_after"}, 32'(idle_err), 32'd0);
    check({name, "_rd_addr_end"}, 32'(rd_addr), 32'(ea));
  endtask

  initial begin
    vec_t vecs [8];
    int acc, k, idle_err;
    bit flushed;
    logic [8:0] sa, ea;
    int len;

    vecs[0] = '{sa: 9'd0,   ea: 9'd7,   len: 8,   first: 32'd0,    last: 32'd21,   rmode: 0, poke: 0};
    vecs[1] = '{sa: 9'd5,   ea: 9'd5,   len: 1,   first: 32'd15,   last: 32'd15,   rmode: 0, poke: 0};
    vecs[2] = '{sa: 9'd510, ea: 9'd1,   len: 4,   first: 32'd1530, last: 32'd3,    rmode: 0, poke: 0};
    vecs[3] = '{sa: 9'd0,   ea: 9'd15,  len: 16,  first: 32'd0,    last: 32'd45,   rmode: 1, poke: 0};
    vecs[4] = '{sa: 9'd100, ea: 9'd130, len: 31,  first: 32'd300,  last: 32'd390,  rmode: 1, poke: 1};
    vecs[5] = '{sa: 9'd511, ea: 9'd511, len: 1,   first: 32'd1533, last: 32'd1533, rmode: 1, poke: 0};
    vecs[6] = '{sa: 9'd3,   ea: 9'd2,   len: 512, first: 32'd9,    last: 32'd6,    rmode: 0, poke: 0};
    vecs[7] = '{sa: 9'd40,  ea: 9'd47,  len: 8,   first: 32'd120,  last: 32'd141,  rmode: 0, poke: 1};

    for (int i = 0; i < 512; i++) ram[i] = 32'(i) * 32'd3;
    rst = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0; flush = 1'b0; inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_valid", 32'(inst_valid), 32'd0);
    check("reset_last", 32'(inst_last), 32'd0);
    check("reset_data", inst_data, 32'd0);
    check("reset_rd_addr", 32'(rd_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i])
      run_program(vecs[i].sa, vecs[i].ea, vecs[i].len, vecs[i].first, vecs[i].last,
                  vecs[i].rmode, vecs[i].poke, $sformatf("vec%0d", i));

    for (int r = 0; r < 6; r++) begin
      sa  = 9'($urandom % 512);
      len = 1 + int'($urandom % 24);
      ea  = 9'(sa + 9'(len - 1));
      run_program(sa, ea, len, word_at(sa), word_at(ea), 1, 0, $sformatf("rnd%0d", r));
    end

    // Flush on the third accepted instruction of 0..15.
    @(negedge clk);
    start_addr = 9'd0; end_addr = 9'd15; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    acc = 0; k = 0; flushed = 0; idle_err = 0;
    while (!flushed && k < 100) begin
      inst_ready = 1'b1;
      #1;
      if (inst_valid) acc++;
      if (acc == 3) begin
        flush = 1'b1;
        flushed = 1;
        #1;
        check("flush_done_same_cycle", 32'(done), 32'd0);
      end
      @(negedge clk);
      k++;
    end
    flush = 1'b0;
    #1;
    check("flush_reached", 32'(flushed), 32'd1);
    check("flush_valid", 32'(inst_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (busy || done || inst_valid) idle_err++;
    end
    check("flush_quiet", 32'(idle_err), 32'd0);
    run_program(9'd20, 9'd21, 2, 32'd60, 32'd63, 0, 0, "after_flush");

    // Asynchronous reset in the middle of a program.
    @(negedge clk);
    start_addr = 9'd0; end_addr = 9'd15; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) begin
      inst_ready = 1'($urandom % 2);
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_valid", 32'(inst_valid), 32'd0);
    check("midrst_last", 32'(inst_last), 32'd0);
    check("midrst_data", inst_data, 32'd0);
    check("midrst_rd_addr", 32'(rd_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_err = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (busy || done || inst_valid) idle_err++;
    end
    check("midrst_quiet", 32'(idle_err), 32'd0);
    run_program(9'd0, 9'd7, 8, 32'd0, 32'd21, 1, 0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
